// File: rtl/lfsr_stim_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_gen_pkg
//  Description : Shared state encoding and default LFSR constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package stim_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] C_DEFAULT_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/lfsr_stim_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stim_gen_if
//  Description : Valid/ready item bus between the stimulus source and sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_stim_gen_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );

endinterface
`default_nettype wire

// File: rtl/lfsr_stim_gen_galois.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_galois
//  Description : Right-shifting Galois LFSR with synchronous load and step.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_galois
    import stim_gen_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = C_DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = C_DEFAULT_SEED
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic [LFSR_W-1:0] load_val,
    input  wire logic              step,
    output logic      [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Load wins over step so a reseed is never lost to a concurrent advance
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stim_gen
//  Description : Emits a counted run of LFSR items on valid/ready, holding
//                each accepted item stable for HOLD_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stim_gen
    import stim_gen_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = C_DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS        = C_DEFAULT_TAPS,
    parameter int                HOLD_CYCLES = 10,
    parameter int                CNT_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              seed_load,
    input  wire logic [LFSR_W-1:0] seed_in,
    input  wire logic [CNT_W-1:0]  num_items,
    lfsr_stim_gen_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic      [CNT_W-1:0]  item_idx
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [CNT_W-1:0]    idx_q,      idx_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;

    logic [LFSR_W-1:0]   w_lfsr;
    logic [LFSR_W-1:0]   w_seed_fix;
    logic                w_load;
    logic                w_step;
    logic [DATA_W-1:0]   w_cur_lo;
    logic [DATA_W-1:0]   w_next_lo;
    logic [DATA_W-1:0]   w_tap_lo;
    logic [CNT_W-1:0]    w_idx_inc;

    assign w_seed_fix = (seed_in == '0) ? SEED : seed_in;
    assign w_load     = (state_q == IDLE) && seed_load;
    assign w_step     = (state_q == HOLD) && (hold_q == '0);
    assign w_idx_inc  = idx_q + CNT_W'(1);

    lfsr_galois #(
        .LFSR_W   (LFSR_W),
        .TAPS     (TAPS),
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_seed_fix),
        .step     (w_step),
        .state    (w_lfsr)
    );

    // A same-cycle reseed must show up in the first item of the run
    assign w_cur_lo = w_load ? w_seed_fix[DATA_W-1:0] : w_lfsr[DATA_W-1:0];
    assign w_tap_lo = w_lfsr[0] ? TAPS[DATA_W-1:0] : '0;

    // Only the low DATA_W bits of the next LFSR state are needed here
    if (DATA_W < LFSR_W) begin : g_next_narrow
        assign w_next_lo = w_lfsr[DATA_W:1] ^ w_tap_lo;
    end else begin : g_next_full
        assign w_next_lo = {1'b0, w_lfsr[LFSR_W-1:1]} ^ w_tap_lo;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_items != '0) begin
                        count_d = num_items;
                        idx_d   = '0;
                        data_d  = w_cur_lo;
                        state_d = PRESENT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PRESENT: begin
                if (bus.data_ready) begin
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    if (w_idx_inc == count_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = w_idx_inc;
                        data_d  = w_next_lo;
                        state_d = PRESENT;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = (state_q == PRESENT);
    assign busy           = (state_q == PRESENT) || (state_q == HOLD);
    assign done           = (state_q == DONE);
    assign item_idx       = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_stim_gen
//  Description : Directed self-checking bench for lfsr_stim_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [15:0] num_items;
    logic        busy;
    logic        done;
    logic [15:0] item_idx;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lfsr_stim_gen_if #(.DATA_W(8)) bus ();

    lfsr_stim_gen #(
        .DATA_W      (8),
        .LFSR_W      (16),
        .SEED        (16'hACE1),
        .TAPS        (16'hB400),
        .HOLD_CYCLES (10),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .num_items (num_items),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .item_idx  (item_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        start     = 1'b0;
        seed_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_total++;
        if (bus.data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.data_out);
        else n_pass++;
        n_total++;
        if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.data_valid);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
        else n_pass++;
        n_total++;
        if (item_idx !== 16'd0) $display("FAIL reset_idx: got %0d want 0", item_idx);
        else n_pass++;
    endtask

    task automatic test_basic_run;
        logic [7:0] exp [3] = '{8'hE1, 8'h70, 8'h38};
        int vcnt = 0;
        int dcnt = 0;
        num_items      = 16'd3;
        bus.data_ready = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
        else n_pass++;
        for (int t = 0; t < 45; t++) begin
            if (bus.data_valid === 1'b1) begin
                n_total++;
                if (vcnt < 3 && bus.data_out === exp[vcnt] && t == 11 * vcnt && item_idx == vcnt)
                    n_pass++;
                else
                    $display("FAIL basic_item%0d: data=%h idx=%0d t=%0d want data=%h idx=%0d t=%0d",
                             vcnt, bus.data_out, item_idx, t, (vcnt < 3) ? exp[vcnt] : 8'h00, vcnt, 11 * vcnt);
                vcnt++;
            end
            if (done === 1'b1) begin
                n_total++;
                if (t == 33 && busy === 1'b0) n_pass++;
                else $display("FAIL basic_done: t=%0d busy=%b want t=33 busy=0", t, busy);
                dcnt++;
            end
            tick();
        end
        n_total++;
        if (vcnt != 3 || dcnt != 1) $display("FAIL basic_counts: items=%0d dones=%0d want 3 1", vcnt, dcnt);
        else n_pass++;
    endtask

    task automatic test_stall;
        int n;
        do_reset();
        bus.data_ready = 1'b0;
        num_items      = 16'd1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hE1)
                $display("FAIL stall_cycle%0d: valid=%b data=%h want 1 e1", i, bus.data_valid, bus.data_out);
            else n_pass++;
            tick();
        end
        bus.data_ready = 1'b1;
        tick();
        n_total++;
        if (bus.data_valid !== 1'b0 || busy !== 1'b1 || bus.data_out !== 8'hE1)
            $display("FAIL stall_accept: valid=%b busy=%b data=%h want 0 1 e1", bus.data_valid, busy, bus.data_out);
        else n_pass++;
        wait_done(20, n);
        n_total++;
        if (n != 10) $display("FAIL stall_hold_len: got %0d want 10", n);
        else n_pass++;
        tick();
    endtask

    task automatic test_seed_load;
        int n;
        seed_in   = 16'h0001;
        seed_load = 1'b1;
        tick();
        seed_load      = 1'b0;
        num_items      = 16'd2;
        bus.data_ready = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h01)
            $display("FAIL seed_item0: valid=%b data=%h want 1 01", bus.data_valid, bus.data_out);
        else n_pass++;
        for (int i = 0; i < 11; i++) tick();
        n_total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h00 || item_idx !== 16'd1)
            $display("FAIL seed_item1: valid=%b data=%h idx=%0d want 1 00 1", bus.data_valid, bus.data_out, item_idx);
        else n_pass++;
        wait_done(20, n);
        n_total++;
        if (n != 11) $display("FAIL seed_done: got %0d want 11", n);
        else n_pass++;
        tick();
    endtask

    task automatic test_seed_zero;
        int n;
        seed_in   = 16'h0000;
        seed_load = 1'b1;
        num_items = 16'd1;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        n_total++;
        if (bus.data_out !== 8'hE1) $display("FAIL seed_zero: got %h want e1", bus.data_out);
        else n_pass++;
        wait_done(20, n);
        n_total++;
        if (n != 11) $display("FAIL seed_zero_done: got %0d want 11", n);
        else n_pass++;
        tick();
    endtask

    task automatic test_zero_items;
        num_items = 16'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.data_valid !== 1'b0)
            $display("FAIL zero_done: done=%b busy=%b valid=%b want 1 0 0", done, busy, bus.data_valid);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || bus.data_valid !== 1'b0)
            $display("FAIL zero_after: done=%b valid=%b want 0 0", done, bus.data_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int saw_done = 0;
        do_reset();
        num_items      = 16'd4;
        bus.data_ready = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        n_total++;
        if (bus.data_out !== 8'h70 || item_idx !== 16'd1)
            $display("FAIL mid_item1: data=%h idx=%0d want 70 1", bus.data_out, item_idx);
        else n_pass++;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || item_idx !== 16'd0)
            $display("FAIL mid_reset: data=%h valid=%b busy=%b done=%b idx=%0d want 00 0 0 0 0",
                     bus.data_out, bus.data_valid, busy, done, item_idx);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done++;
        end
        n_total++;
        if (saw_done != 0) $display("FAIL mid_no_done: got %0d active cycles want 0", saw_done);
        else n_pass++;
        num_items = 16'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (bus.data_out !== 8'hE1) $display("FAIL mid_restart: got %h want e1", bus.data_out);
        else n_pass++;
        wait_done(20, saw_done);
        tick();
    endtask

    task automatic test_persist_and_ignore;
        int n;
        do_reset();
        num_items      = 16'd2;
        bus.data_ready = 1'b1;
        start          = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start     = 1'b1;
        num_items = 16'd5;
        tick();
        start = 1'b0;
        wait_done(40, n);
        n_total++;
        if (n != 18) $display("FAIL ignore_done_time: got %0d want 18", n);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ignore_idle: done=%b busy=%b want 0 0", done, busy);
        else n_pass++;
        num_items = 16'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (bus.data_out !== 8'h38) $display("FAIL persist_item: got %h want 38", bus.data_out);
        else n_pass++;
        wait_done(20, n);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        seed_load      = 1'b0;
        seed_in        = 16'h0000;
        num_items      = 16'd0;
        bus.data_ready = 1'b0;
        test_reset();
        test_basic_run();
        test_stall();
        test_seed_load();
        test_seed_zero();
        test_zero_items();
        test_reset_mid_run();
        test_persist_and_ignore();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
